// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command path: op/cond codes, flag bit
// positions inside the packed {zero, carry, overflow, negative} vector, FSM states.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_LT     = 3'b010,
    COND_GE     = 3'b011,
    COND_LTU    = 3'b100,
    COND_GEU    = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  localparam logic [1:0] FLAG_Z = 2'd3;
  localparam logic [1:0] FLAG_C = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd1;
  localparam logic [1:0] FLAG_N = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Branch-condition verdict from a packed {Z, C, V, N} flag vector.
// Carry is taken as borrow for sub, so LTU is simply C.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic signed_lt;

  always_comb begin
    signed_lt = flags[FLAG_N] ^ flags[FLAG_V];
    cond_true = 1'b0;
    case (cond)
      COND_EQ:     cond_true = flags[FLAG_Z];
      COND_NE:     cond_true = !flags[FLAG_Z];
      COND_LT:     cond_true = signed_lt;
      COND_GE:     cond_true = !signed_lt;
      COND_LTU:    cond_true = flags[FLAG_C];
      COND_GEU:    cond_true = !flags[FLAG_C];
      COND_ALWAYS: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Valid/ready front end for the external combinational ALU: registers a command,
// captures result and flags one cycle later and holds them until the consumer accepts.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_cond,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_cond_true,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);

  // b is passed to the ALU whole; the shift field width must still match WIDTH
  if ((32'd1 << SHAMT_W) != WIDTH) begin : g_bad_shamt
    $error("SHAMT_W does not match log2(WIDTH)");
  end

  seq_state_e state, state_nx;
  logic [2:0] cond_q;
  logic [3:0] live_flags;
  logic       live_cond;
  logic       load_cmd;
  logic       capture;
  logic       arith_op;

  assign live_flags = {alu_zero, alu_carry, alu_ovf, alu_neg};
  assign arith_op   = (alu_sel == ALU_ADD) || (alu_sel == ALU_SUB);

  alu_cond_eval u_cond_eval (
    .cond      (cond_q),
    .flags     (live_flags),
    .cond_true (live_cond)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    load_cmd  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          load_cmd = 1'b1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture  = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      cond_q        <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      rsp_cond_true <= 1'b0;
    end else begin
      if (load_cmd) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
        cond_q  <= cmd_cond;
      end
      if (capture) begin
        rsp_result    <= alu_result;
        rsp_flags     <= live_flags;
        rsp_cond_true <= live_cond;
      end
    end
  end

  // A capture that overflows beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)                              ovf_sticky <= 1'b0;
    else if (capture && arith_op && alu_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clear)                   ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU attached; a scoreboard queue is
// filled by the stimulus and drained by a monitor on every response handshake.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_cond;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_ovf;
  logic        alu_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_cond_true;
  logic        ovf_sticky;
  logic        ovf_clear;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        ct;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_cond      (cmd_cond),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_sel       (alu_sel),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .alu_ovf       (alu_ovf),
    .alu_neg       (alu_neg),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .rsp_cond_true (rsp_cond_true),
    .ovf_sticky    (ovf_sticky),
    .ovf_clear     (ovf_clear)
  );

  // Behavioural 32-bit ALU; sub reports borrow on carry
  logic [32:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_sel)
      3'b000: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_carry  = sum[32];
        alu_ovf    = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b001: begin
        sum        = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_carry  = alu_a < alu_b;
        alu_ovf    = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b010: alu_result = alu_a | alu_b;
      3'b011: alu_result = alu_a ^ alu_b;
      3'b100: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b101: alu_result = alu_a << alu_b[4:0];
      3'b110: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);
  assign alu_neg  = alu_result[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every completed response handshake must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
          chk("rsp_cond_true", {31'd0, rsp_cond_true}, {31'd0, e.ct});
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] cond, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                       input logic ect, input bit push);
    int n;
    if (push) sb.push_back('{res: er, flags: ef, ct: ect});
    @(posedge clk) #1;
    cmd_op = op; cmd_cond = cond; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk) #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("rsp_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cond = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1; ovf_clear = 1'b0;

    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_result", rsp_result, 32'd0);
    chk("post_rst_flags", {28'd0, rsp_flags}, 32'd0);
    chk("post_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("post_rst_alu_a", alu_a, 32'd0);

    // Add wrap with latency check
    issue(3'b000, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);
    finish_rsp();

    // Signed/unsigned compare via sub
    issue(3'b001, 3'b010, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0101, 1'b1, 1'b1); finish_rsp();
    issue(3'b001, 3'b100, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0101, 1'b1, 1'b1); finish_rsp();
    issue(3'b001, 3'b101, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0101, 1'b0, 1'b1); finish_rsp();
    issue(3'b001, 3'b011, 32'd9, 32'd9, 32'h0,         4'b1000, 1'b1, 1'b1); finish_rsp();
    chk("sticky_no_ovf", {31'd0, ovf_sticky}, 32'd0);

    // Overflow sticky: set, clear, then clear colliding with a set
    issue(3'b000, 3'b001, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0011, 1'b1, 1'b1);
    finish_rsp();
    chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    @(posedge clk) #1; ovf_clear = 1'b1;
    @(posedge clk) #1; ovf_clear = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);
    issue(3'b000, 3'b111, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0011, 1'b0, 1'b1);
    ovf_clear = 1'b1;
    @(posedge clk) #1; ovf_clear = 1'b0;
    finish_rsp();
    chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);

    // Shifts and slt; b is driven to the ALU unmodified
    issue(3'b111, 3'b110, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b0001, 1'b1, 1'b1);
    @(negedge clk);
    chk("sra_alu_b", alu_b, 32'h24);
    chk("sra_alu_sel", {29'd0, alu_sel}, 32'd7);
    chk("sra_alu_a", alu_a, 32'h8000_0000);
    finish_rsp();
    issue(3'b101, 3'b000, 32'h1, 32'd31, 32'h8000_0000, 4'b0001, 1'b0, 1'b1); finish_rsp();
    issue(3'b110, 3'b100, 32'h8000_0000, 32'h1F, 32'h1, 4'b0000, 1'b0, 1'b1); finish_rsp();
    issue(3'b100, 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000, 1'b1, 1'b1); finish_rsp();

    // Backpressure with a second command waiting
    rsp_ready = 1'b0;
    sb.push_back('{res: 32'h0, flags: 4'b1000, ct: 1'b0});
    issue(3'b010, 3'b110, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 4'b0001, 1'b1, 1'b0);
    sb.push_front('{res: 32'hF0F0_0F0F, flags: 4'b0001, ct: 1'b1});
    cmd_op = 3'b011; cmd_cond = 3'b001; cmd_a = 32'hFF; cmd_b = 32'hFF; cmd_valid = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_valid_up", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result_hold", rsp_result, 32'hF0F0_0F0F);
      chk("bp_flags_hold", {28'd0, rsp_flags}, 32'h1);
      chk("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
    end
    @(posedge clk) #1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk) #1; cmd_valid = 1'b0;
    finish_rsp();

    // Reset during EXEC discards an overflowing command
    issue(3'b000, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk) #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("abort_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("abort_result", rsp_result, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    issue(3'b000, 3'b000, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1'b1);
    finish_rsp();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side front end for the combinational 32-bit ALU. It accepts ALU commands over a valid/ready interface and registers the operands. It drives the ALU's `a`/`b`/`alu_sl` inputs, then captures the result and the four flags (zero, carry_out, overflow, negative). It returns them over a valid/ready response interface together with a branch-condition verdict, so pipeline and branch logic never have to touch the raw ALU flags.

Parameters:
- WIDTH, 32, datapath width of operands, result and ALU ports.
- SHAMT_W, 5, shift-amount bits taken from b (log2 WIDTH); passed through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  ALU select: 000 add, 001 sub, 010 or, 011 xor, 100 slt, 101 sll, 110 srl, 111 sra.
- cmd_cond  input  3  condition: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 110 ALWAYS, 111 NEVER.
- cmd_a  input  WIDTH  operand a.
- cmd_b  input  WIDTH  operand b.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_sel  output  3  to ALU select.
- alu_result  input  WIDTH  from ALU.
- alu_zero, alu_carry, alu_ovf, alu_neg  input  1 each  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_flags  output  4  {zero, carry, overflow, negative}, captured.
- rsp_cond_true  output  1  evaluated condition.
- ovf_sticky  output  1  set by any captured add/sub with overflow=1.
- ovf_clear  input  1  clears ovf_sticky.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. Everything below is sampled on the rising edge of clk.
- Reset values: state=IDLE; cmd_ready=1 after reset deasserts (0 while rst=1); rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_cond_true=0; ovf_sticky=0; alu_a/alu_b/alu_sel=0.
- FSM has three states.
  - IDLE: cmd_ready=1. A transfer is `cmd_valid && cmd_ready`. On transfer, register a, b, op and cond into alu_a/alu_b/alu_sel/cond_q, then go to EXEC.
  - EXEC: cmd_ready=0. The ALU output is combinational from the registered inputs. At the end of the cycle, capture alu_result and the flags into rsp_*, compute rsp_cond_true, then go to RESP.
  - RESP: rsp_valid=1; rsp_* held stable until `rsp_valid && rsp_ready`. On that cycle go to IDLE and drop rsp_valid the next cycle.
- Latency and throughput: command accepted in cycle N, rsp_valid=1 from cycle N+2. With rsp_ready held high, a new command can be accepted every 3 cycles. No command is accepted while a response is pending.
- alu_a/alu_b/alu_sel hold their last values outside EXEC; no glitching is required for correctness.
- Flag convention for sub: carry = borrow (1 when a<b unsigned).
- Condition evaluation from the captured flags Z, C, V, N:
  - EQ = Z; NE = !Z.
  - LT = N^V; GE = !(N^V).
  - LTU = C; GEU = !C.
  - ALWAYS = 1; NEVER = 0.
  - Conditions are evaluated for every op; they are only meaningful for sub, and that is the caller's responsibility.
- ovf_sticky:
  - Set on the EXEC capture edge when alu_sel is 000 or 001 and alu_ovf=1.
  - Cleared by ovf_clear. If clear and set occur on the same edge, set wins.
- Reset mid-operation (EXEC or RESP): the command and response are discarded, all outputs return to their reset values, and no response is produced.
- A response is never dropped: rsp_* must not change while `rsp_valid && !rsp_ready`.

Decomposition:
- Shared package (alu_pkg): WIDTH default; op encodings ALU_ADD..ALU_SRA; cond encodings COND_EQ..COND_NEVER; FLAG_* bit indices; the FSM state enum.
- One natural sub-module: alu_cond_eval (combinational: cond + 4 flags -> true), reusable by branch logic.
- The ALU is not instantiated inside this block. It is connected at the parent level. The testbench instantiates both.

Test Plan:
- Add wrap: op=000, a=0xFFFFFFFF, b=0x00000001, cond=EQ -> result 0x00000000, Z=1 C=1 V=0 N=0, cond_true=1, rsp_valid exactly 2 cycles after accept.
- Signed/unsigned compare: op=001, a=5, b=7, cond=LT -> result 0xFFFFFFFE, N=1 C=1 V=0, cond_true=1. Repeat with cond=LTU -> 1; cond=GEU -> 0.
- Overflow sticky: op=000, a=0x7FFFFFFF, b=1 -> result 0x80000000, V=1 N=1, ovf_sticky=1. Pulse ovf_clear -> 0. Pulse ovf_clear on the same edge as another overflow capture -> stays 1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result/flags constant, cmd_ready=0 throughout, cmd_valid held high and not accepted. rsp_ready=1 -> handshake, then cmd_ready=1 the next cycle.
- Shift passthrough: op=111, a=0x80000000, b=0x00000024 (shamt field=4) -> alu_b=0x24 driven, result 0xF8000000.
- Reset mid-op: assert rst during EXEC for 1 cycle -> no response ever appears, rsp_valid=0, ovf_sticky=0; a fresh add 2+3 then returns 5.
